// File: rtl/byte_memory_controller_pkg.sv
// Shared state encoding and default timing for the byte memory controller.
// The helper functions size the single phase counter from the three phase lengths.
package byte_memory_controller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SETTLE = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam int DEFAULT_DATA_W        = 8;
  localparam int DEFAULT_ADDR_W        = 2;
  localparam int DEFAULT_SETUP_CYCLES  = 1;
  localparam int DEFAULT_STROBE_CYCLES = 2;
  localparam int DEFAULT_HOLD_CYCLES   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int phase_count_width(input int setup, input int strobe, input int hold);
    return $clog2(max3(setup, strobe, hold) + 1);
  endfunction

endpackage

// File: rtl/byte_memory_controller_phase_timer.sv
// Loadable down-counter shared by every timed phase; done is high while the count is zero.
// Loading N-1 on phase entry makes done rise on the phase's last cycle.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/byte_memory_controller.sv
// Clocked initiator for the latch-based byte memory: sequences setup, store strobe and hold
// around each write so latched data never races the enable, then returns a one-cycle response.
module byte_memory_controller
  import byte_memory_controller_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int SETUP_CYCLES  = DEFAULT_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_memory
);

  localparam int CNT_W = phase_count_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic              op_write;
  logic              accept;
  logic              sample_rsp;
  logic              timer_load;
  logic              timer_done;
  logic [CNT_W-1:0]  timer_value;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign sample_rsp = timer_done &&
                      (((state == W_HOLD) && op_write) || ((state == R_SETTLE) && !op_write));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Each timed phase reloads the shared counter for the phase it is about to enter.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state  = req_write ? W_SETUP : R_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETUP_LOAD;
        end
      end
      W_SETUP: begin
        if (timer_done) begin
          next_state  = W_STROBE;
          timer_load  = 1'b1;
          timer_value = STROBE_LOAD;
        end
      end
      W_STROBE: begin
        if (timer_done) begin
          next_state  = W_HOLD;
          timer_load  = 1'b1;
          timer_value = HOLD_LOAD;
        end
      end
      W_HOLD: begin
        if (timer_done) begin
          next_state = RESP;
        end
      end
      R_SETTLE: begin
        if (timer_done) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  phase_timer #(
    .W(CNT_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Store follows the registered next state, so it rises only after a full setup cycle
  // and drops one edge before addr/data are allowed to move.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_store <= 1'b0;
      op_write  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_store <= (next_state == W_STROBE);
      rsp_valid <= sample_rsp;
      if (sample_rsp) begin
        rsp_rdata <= mem_memory;
      end
      if (accept) begin
        mem_addr <= req_addr;
        mem_data <= req_wdata;
        op_write <= req_write;
      end
    end
  end

endmodule

// File: tb/tb_byte_memory_controller.sv
// Directed bench for byte_memory_controller: default-timing DUT plus a SETUP=3/STROBE=1/HOLD=2
// instance, each driving a small model of the latch-based 4-byte memory.
module tb_byte_memory_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_valid0, req_valid1;

  logic       ready0, rsp_valid0, store0;
  logic [7:0] rdata0, data0, memory0;
  logic [1:0] addr0;
  logic       ready1, rsp_valid1, store1;
  logic [7:0] rdata1, data1, memory1;
  logic [1:0] addr1;

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;
  int accepts0 = 0;
  int exp_accepts0 = 0;
  int margin_viol0 = 0;
  int margin_viol1 = 0;

  logic       cur_ready, cur_rsp, cur_store;
  logic [7:0] cur_rdata;

  always #5 clk = ~clk;

  byte_memory_controller dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid0),
    .req_ready  (ready0),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid0),
    .rsp_rdata  (rdata0),
    .mem_addr   (addr0),
    .mem_data   (data0),
    .mem_store  (store0),
    .mem_memory (memory0)
  );

  byte_memory_controller #(
    .SETUP_CYCLES  (3),
    .STROBE_CYCLES (1),
    .HOLD_CYCLES   (2)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid1),
    .req_ready  (ready1),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid1),
    .rsp_rdata  (rdata1),
    .mem_addr   (addr1),
    .mem_data   (data1),
    .mem_store  (store1),
    .mem_memory (memory1)
  );

  // Latch memory model: transparent while store is high, holding the byte once it falls.
  logic [7:0] mem0 [4];
  logic [7:0] mem1 [4];
  always_ff @(posedge clk) begin
    if (store0) mem0[addr0] <= data0;
    if (store1) mem1[addr1] <= data1;
  end
  assign memory0 = store0 ? data0 : mem0[addr0];
  assign memory1 = store1 ? data1 : mem1[addr1];

  always_comb begin
    cur_ready = (sel == 0) ? ready0     : ready1;
    cur_rsp   = (sel == 0) ? rsp_valid0 : rsp_valid1;
    cur_store = (sel == 0) ? store0     : store1;
    cur_rdata = (sel == 0) ? rdata0     : rdata1;
  end

  always_ff @(posedge clk) begin
    if (req_valid0 && ready0) accepts0 <= accepts0 + 1;
  end

  // addr/data may only move across an edge where store is low on both sides.
  logic [9:0] prev_v0 = '0, prev_v1 = '0;
  logic       prev_s0 = 1'b0, prev_s1 = 1'b0, prev_r = 1'b1;
  always @(negedge clk) begin
    prev_v0 <= {addr0, data0};
    prev_v1 <= {addr1, data1};
    prev_s0 <= store0;
    prev_s1 <= store1;
    prev_r  <= reset;
    if (({addr0, data0} !== prev_v0) && (store0 || prev_s0) && !(reset || prev_r))
      margin_viol0 <= margin_viol0 + 1;
    if (({addr1, data1} !== prev_v1) && (store1 || prev_s1) && !(reset || prev_r))
      margin_viol1 <= margin_viol1 + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int dut_sel, input bit wr, input logic [1:0] addr,
                               input logic [7:0] data, input int exp_lat, input logic [7:0] exp_rdata,
                               input int exp_store_len, input int exp_store_start,
                               input bit keep_busy, input string tag);
    int wait_cycles;
    int cyc;
    int store_len;
    int store_start;
    int ready_leak;
    sel = dut_sel;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    if (dut_sel == 0) req_valid0 = 1'b1;
    else              req_valid1 = 1'b1;
    #1;
    wait_cycles = 0;
    while (!cur_ready && wait_cycles < 10) begin
      @(negedge clk);
      #1;
      wait_cycles++;
    end
    checkOutput({tag, "_accept_wait"}, wait_cycles, 0);
    if (dut_sel == 0) exp_accepts0++;
    @(negedge clk);
    cyc = 1;
    if (!keep_busy) begin
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
    end
    store_len   = 0;
    store_start = 0;
    ready_leak  = 0;
    while (1) begin
      if (cur_store) begin
        if (store_len == 0) store_start = cyc;
        store_len++;
      end
      if (cur_ready) ready_leak++;
      if (cur_rsp || cyc >= 40) break;
      if (keep_busy) begin
        req_write = 1'($urandom_range(0, 1));
        req_addr  = 2'($urandom_range(0, 3));
        req_wdata = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, exp_lat);
    checkOutput({tag, "_rdata"}, cur_rdata, exp_rdata);
    checkOutput({tag, "_store_len"}, store_len, exp_store_len);
    checkOutput({tag, "_store_start"}, store_start, exp_store_start);
    checkOutput({tag, "_busy_ready"}, ready_leak, 0);
  endtask

  task automatic resetMidStrobe();
    int w;
    bit saw_rsp;
    sel = 0;
    @(negedge clk);
    req_write  = 1'b1;
    req_addr   = 2'd0;
    req_wdata  = 8'h77;
    req_valid0 = 1'b1;
    exp_accepts0++;
    @(negedge clk);
    req_valid0 = 1'b0;
    w = 0;
    while (!store0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rst_store_seen", store0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_store_drop", store0, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid0, 1'b0);
    checkOutput("rst_ready_low", ready0, 1'b0);
    checkOutput("rst_addr", addr0, 2'd0);
    saw_rsp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_rsp |= rsp_valid0;
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready_after", ready0, 1'b1);
    repeat (3) begin
      saw_rsp |= rsp_valid0;
      @(negedge clk);
    end
    checkOutput("rst_no_response", saw_rsp, 1'b0);
  endtask

  logic [7:0] iso_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int         rd_order [4] = '{3, 0, 1, 2};

  initial begin
    reset      = 1'b1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    checkOutput("init_ready", ready0, 1'b0);
    checkOutput("init_rsp_valid", rsp_valid0, 1'b0);
    checkOutput("init_rsp_rdata", rdata0, 8'h00);
    checkOutput("init_mem_addr", addr0, 2'd0);
    checkOutput("init_mem_data", data0, 8'h00);
    checkOutput("init_mem_store", store0, 1'b0);
    checkOutput("init_dut1_store", store1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("init_ready_after", ready0, 1'b1);

    applyStimulus(0, 1'b1, 2'd2, 8'hA5, 5, 8'hA5, 2, 2, 1'b0, "wr_a5");
    applyStimulus(0, 1'b0, 2'd2, 8'h00, 2, 8'hA5, 0, 0, 1'b0, "rd_a5");

    resetMidStrobe();

    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1'b1, 2'(i), iso_data[i], 5, iso_data[i], 2, 2, 1'b0, $sformatf("iso_wr%0d", i));
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1'b0, 2'(rd_order[i]), 8'h00, 2, iso_data[rd_order[i]], 0, 0, 1'b0,
                    $sformatf("iso_rd%0d", i));

    applyStimulus(0, 1'b1, 2'd1, 8'hFF, 5, 8'hFF, 2, 2, 1'b0, "ovw_ff");
    applyStimulus(0, 1'b1, 2'd1, 8'h00, 5, 8'h00, 2, 2, 1'b0, "ovw_00");
    applyStimulus(0, 1'b0, 2'd1, 8'h00, 2, 8'h00, 0, 0, 1'b0, "ovw_rd");

    applyStimulus(0, 1'b1, 2'd3, 8'h5A, 5, 8'h5A, 2, 2, 1'b1, "hs_wr");
    applyStimulus(0, 1'b0, 2'd3, 8'h00, 2, 8'h5A, 0, 0, 1'b1, "hs_rd");
    applyStimulus(0, 1'b0, 2'd2, 8'h00, 2, 8'h33, 0, 0, 1'b0, "hs_rd2");
    @(negedge clk);
    checkOutput("accept_count", accepts0, exp_accepts0);

    applyStimulus(1, 1'b1, 2'd1, 8'h3C, 7, 8'h3C, 1, 4, 1'b0, "mg_wr1");
    applyStimulus(1, 1'b1, 2'd2, 8'hC3, 7, 8'hC3, 1, 4, 1'b0, "mg_wr2");
    applyStimulus(1, 1'b0, 2'd1, 8'h00, 4, 8'h3C, 0, 0, 1'b0, "mg_rd1");
    applyStimulus(1, 1'b0, 2'd2, 8'h00, 4, 8'hC3, 0, 0, 1'b0, "mg_rd2");

    repeat (2) @(negedge clk);
    checkOutput("margin_dut0", margin_viol0, 0);
    checkOutput("margin_dut1", margin_viol1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
